// File: rtl/axi4_wburst_checker.sv
// AXI4 write-burst length checker: per-master AW/W length FIFOs,
// compare heads, sticky length/overflow errors and burst counters.
module axi4_wburst_checker #(
    parameter int NUM_MASTERS = 15,
    parameter int DEPTH       = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_MASTERS-1:0]           m_awvalid,
    input  logic [NUM_MASTERS-1:0]           m_awready,
    input  logic [NUM_MASTERS*8-1:0]         m_awlen,
    input  logic [NUM_MASTERS-1:0]           m_wvalid,
    input  logic [NUM_MASTERS-1:0]           m_wready,
    input  logic [NUM_MASTERS-1:0]           m_wlast,
    input  logic                             clr,
    output logic [NUM_MASTERS-1:0]           err_len,
    output logic [NUM_MASTERS-1:0]           err_ovf,
    output logic                             err_any,
    output logic [3:0]                       first_err_id,
    output logic                             first_err_vld,
    output logic [NUM_MASTERS*CNT_WIDTH-1:0] burst_cnt
);

    localparam int PW = $clog2(DEPTH);

    logic [NUM_MASTERS-1:0] len_ev;
    logic [NUM_MASTERS-1:0] ovf_ev;
    logic [NUM_MASTERS-1:0] err_ev;
    logic [3:0]             pick;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_m
        logic [8:0]           awq [DEPTH];
        logic [8:0]           wq  [DEPTH];
        logic [PW:0]          aw_wp, aw_rp, w_wp, w_rp;
        logic [8:0]           beat;
        logic [CNT_WIDTH-1:0] cnt;
        logic                 aw_hs, w_hs, w_push;
        logic                 aw_full, w_full, pop, wrap;
        logic                 aw_wr, w_wr;
        logic                 hit, miss, elen, eovf;

        assign aw_hs   = m_awvalid[g] & m_awready[g];
        assign w_hs    = m_wvalid[g] & m_wready[g];
        assign w_push  = w_hs & m_wlast[g];
        assign aw_full = (aw_wp[PW] != aw_rp[PW]) &&
                         (aw_wp[PW-1:0] == aw_rp[PW-1:0]);
        assign w_full  = (w_wp[PW] != w_rp[PW]) &&
                         (w_wp[PW-1:0] == w_rp[PW-1:0]);
        assign pop     = (aw_wp != aw_rp) && (w_wp != w_rp);
        assign wrap    = w_hs & ~m_wlast[g] & (beat == 9'd255);
        assign aw_wr   = aw_hs & (~aw_full | pop);
        assign w_wr    = w_push & (~w_full | pop);

        assign len_ev[g] = miss | wrap;
        assign ovf_ev[g] = (aw_hs & aw_full & ~pop) |
                           (w_push & w_full & ~pop);

        // Payload storage needs no reset; pointers define validity.
        always_ff @(posedge aclk) begin
            if (aw_wr) awq[aw_wp[PW-1:0]] <= {1'b0, m_awlen[8*g +: 8]} + 9'd1;
            if (w_wr)  wq[w_wp[PW-1:0]]   <= beat + 9'd1;
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                aw_wp <= '0;
                aw_rp <= '0;
                w_wp  <= '0;
                w_rp  <= '0;
                beat  <= '0;
                hit   <= 1'b0;
                miss  <= 1'b0;
                elen  <= 1'b0;
                eovf  <= 1'b0;
                cnt   <= '0;
            end else begin
                if (aw_wr) aw_wp <= aw_wp + (PW+1)'(1);
                if (w_wr)  w_wp  <= w_wp + (PW+1)'(1);
                if (pop) begin
                    aw_rp <= aw_rp + (PW+1)'(1);
                    w_rp  <= w_rp + (PW+1)'(1);
                end
                hit  <= pop && (awq[aw_rp[PW-1:0]] == wq[w_rp[PW-1:0]]);
                miss <= pop && (awq[aw_rp[PW-1:0]] != wq[w_rp[PW-1:0]]);
                if (w_hs)
                    beat <= (m_wlast[g] || beat == 9'd255) ? 9'd0 : beat + 9'd1;
                elen <= (elen & ~clr) | len_ev[g];
                eovf <= (eovf & ~clr) | ovf_ev[g];
                if (clr)
                    cnt <= CNT_WIDTH'(hit);
                else if (hit && !(&cnt))
                    cnt <= cnt + CNT_WIDTH'(1);
            end
        end

        assign err_len[g] = elen;
        assign err_ovf[g] = eovf;
        assign burst_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt;
    end

    assign err_ev  = len_ev | ovf_ev;
    assign err_any = |{err_len, err_ovf};

    // Downward scan leaves the lowest erroring index.
    always_comb begin
        pick = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--)
            if (err_ev[i]) pick = 4'(i);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            first_err_vld <= 1'b0;
            first_err_id  <= '0;
        end else if ((|err_ev) && (!first_err_vld || clr)) begin
            first_err_vld <= 1'b1;
            first_err_id  <= pick;
        end else if (clr) begin
            first_err_vld <= 1'b0;
            first_err_id  <= '0;
        end
    end

endmodule
